// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'hFFFF;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pcplus2;
  } fetch_entry_t;

  typedef enum logic {
    RESET_HOLD,
    RUN
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory channel: in-order requests with a ready handshake, responses flagged by rvalid.
interface instr_fetch_unit_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a flush input; holds fetched instructions or in-flight fetch addresses.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clear,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues in-order word fetches and buffers returned instructions
// for the IF/ID register, flushing on branch redirects.
module instr_fetch_unit #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall,
  input  logic                      redirect_valid,
  input  logic [15:0]               redirect_pc,
  instr_fetch_unit_if.master        imem,
  output logic [15:0]               instr_out,
  output logic [15:0]               pcplus2_out,
  output logic                      fetch_valid
);

  import fetch_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t     state_q, state_d;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;

  logic             req_c;
  logic             accept;
  logic             resp_keep;
  logic             resp_drop;

  fetch_entry_t     buf_wdata;
  fetch_entry_t     buf_head;
  logic             buf_push, buf_pop;
  logic [CNT_W-1:0] buf_count;
  logic             buf_full, buf_empty;

  logic [15:0]      tag_head;
  logic             tag_push, tag_pop;
  logic [CNT_W-1:0] tag_count;
  logic             tag_full, tag_empty;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (buf_push),
    .push_data (buf_wdata),
    .pop       (buf_pop),
    .clear     (redirect_valid),
    .head      (buf_head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_tag_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (tag_push),
    .push_data (fetch_pc_q),
    .pop       (tag_pop),
    .clear     (redirect_valid),
    .head      (tag_head),
    .count     (tag_count),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  // Buffered plus in-flight entries never exceed DEPTH, so every response has a free slot.
  assign req_c = (state_q == RUN) && !redirect_valid &&
                 (({1'b0, buf_count} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH));

  assign accept    = req_c && imem.imem_ready;
  assign resp_keep = imem.imem_rvalid && !redirect_valid && (discard_q == '0) && !tag_empty;
  assign resp_drop = imem.imem_rvalid && !redirect_valid && (discard_q != '0);

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = fetch_pc_q;

  assign buf_wdata.instr   = imem.imem_rdata;
  assign buf_wdata.pcplus2 = tag_head + 16'd2;
  assign buf_push          = resp_keep;
  assign tag_push          = accept;
  assign tag_pop           = resp_keep;
  assign buf_pop           = fetch_valid && !stall && !redirect_valid;

  assign fetch_valid = !buf_empty;
  assign instr_out   = fetch_valid ? buf_head.instr   : NOP_INSTR;
  assign pcplus2_out = fetch_valid ? buf_head.pcplus2 : 16'h0000;

  always_comb begin
    state_d       = RUN;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      // Everything still in flight belongs to the old path, including a response landing now.
      fetch_pc_d    = redirect_pc & 16'hFFFE;
      outstanding_d = outstanding_q - CNT_W'(imem.imem_rvalid);
      discard_d     = outstanding_d;
    end else begin
      if (accept) begin
        fetch_pc_d = fetch_pc_q + 16'd2;
      end
      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem.imem_rvalid);
      if (resp_drop) begin
        discard_d = discard_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RESET_HOLD;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  a_no_buf_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    buf_push |-> (!buf_full || buf_pop));

  a_no_tag_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    tag_push |-> (!tag_full || tag_pop));

  a_tags_in_flight: assert property (@(posedge clk) disable iff (!reset_n)
    tag_count <= outstanding_q);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random traffic, checked
// against a queue model of memory, the fetch buffer and the expected program-order stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [15:0] NOP   = 16'hFFFF;

  typedef struct {
    logic [15:0] addr;
    int          due;
    bit          kept;
  } req_t;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] instr_out;
  logic [15:0] pcplus2_out;
  logic        fetch_valid;

  instr_fetch_unit_if imem ();

  instr_fetch_unit #(
    .DEPTH     (DEPTH),
    .RESET_PC  (16'h0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .instr_out      (instr_out),
    .pcplus2_out    (pcplus2_out),
    .fetch_valid    (fetch_valid)
  );

  req_t        pending[$];
  logic [15:0] buf_q[$];
  logic [15:0] exp_req_pc;
  bit          running;
  int          cyc;
  int          num_compared;
  int          num_mismatched;
  int          first_accept;
  int          first_valid;
  int          mem_lat_max;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_compared++;
    if (got !== exp) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs and the memory response, check outputs, advance the model.
  task automatic applyStimulus(input logic st, input logic rd, input logic [15:0] rpc,
                               input logic rdy, input logic allow);
    req_t        r;
    bit          resp_now;
    bit          exp_req;
    bit          pop_now;
    logic [15:0] exp_p2;
    @(negedge clk);
    stall           = st;
    redirect_valid  = rd;
    redirect_pc     = rpc;
    imem.imem_ready = rdy;
    resp_now        = 1'b0;
    r               = '{addr: 16'h0000, due: 0, kept: 1'b0};
    if (allow && pending.size() > 0 && pending[0].due <= cyc) begin
      r        = pending.pop_front();
      resp_now = 1'b1;
    end
    imem.imem_rvalid = resp_now;
    imem.imem_rdata  = resp_now ? mem_word(r.addr) : 16'($urandom);
    #1;
    exp_req = running && !rd && (buf_q.size() + pending.size() + int'(resp_now) < DEPTH);
    checkOutput("imem_req", 32'(imem.imem_req), 32'(exp_req));
    if (exp_req) checkOutput("imem_addr", 32'(imem.imem_addr), 32'(exp_req_pc));
    checkOutput("fetch_valid", 32'(fetch_valid), 32'(buf_q.size() > 0));
    if (buf_q.size() > 0) begin
      exp_p2 = buf_q[0] + 16'd2;
      checkOutput("instr_out", 32'(instr_out), 32'(mem_word(buf_q[0])));
      checkOutput("pcplus2_out", 32'(pcplus2_out), 32'(exp_p2));
    end else begin
      checkOutput("instr_nop", 32'(instr_out), 32'(NOP));
      checkOutput("pcplus2_zero", 32'(pcplus2_out), 32'd0);
    end
    if (first_accept < 0 && imem.imem_req && rdy) first_accept = cyc;
    if (first_valid < 0 && fetch_valid) first_valid = cyc;

    pop_now = (buf_q.size() > 0) && !st && !rd;
    if (rd) begin
      foreach (pending[i]) pending[i].kept = 1'b0;
      buf_q.delete();
      exp_req_pc = rpc & 16'hFFFE;
    end else begin
      if (pop_now) void'(buf_q.pop_front());
      if (resp_now && r.kept) buf_q.push_back(r.addr);
    end
    if (exp_req && rdy) begin
      pending.push_back('{addr: exp_req_pc, due: cyc + int'($urandom_range(mem_lat_max, 1)),
                         kept: 1'b1});
      exp_req_pc = exp_req_pc + 16'd2;
    end
    running = 1'b1;
    cyc++;
  endtask

  // Asynchronous reset at an arbitrary point; outputs must fall back at once.
  task automatic resetDut();
    reset_n = 1'b0;
    #1;
    checkOutput("rst_req", 32'(imem.imem_req), 32'd0);
    checkOutput("rst_valid", 32'(fetch_valid), 32'd0);
    checkOutput("rst_instr", 32'(instr_out), 32'(NOP));
    checkOutput("rst_pcplus2", 32'(pcplus2_out), 32'd0);
    pending.delete();
    buf_q.delete();
    running          = 1'b0;
    exp_req_pc       = 16'h0000;
    first_accept     = -1;
    first_valid      = -1;
    stall            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 16'h0000;
    imem.imem_ready  = 1'b0;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = 16'h0000;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    bit hit;
    num_compared   = 0;
    num_mismatched = 0;
    cyc            = 0;
    mem_lat_max    = 1;

    // Plan 1: always-ready memory with single-cycle latency.
    resetDut();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("first_latency", 32'(first_valid - first_accept), 32'd2);

    // Plan 2: stall with the first instruction at the head until the buffer fills.
    resetDut();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      hit = (buf_q.size() > 0);
    end
    checkOutput("s2_setup", 32'(hit), 32'd1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
    checkOutput("stall_req", 32'(imem.imem_req), 32'd0);
    checkOutput("stall_instr", 32'(instr_out), 32'(mem_word(16'h0000)));
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Plan 3: redirect to an odd address with two requests outstanding.
    resetDut();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("s3_outstanding", 32'(pending.size()), 32'd2);
    applyStimulus(1'b0, 1'b1, 16'h0041, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Plan 4: redirect and stall together while a response lands.
    resetDut();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      hit = (buf_q.size() > 0) && (pending.size() > 0) && (pending[0].due <= cyc);
    end
    checkOutput("s4_setup", 32'(hit), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h0200, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Plan 5: memory not ready for three cycles while 0x0006 is requested.
    resetDut();
    for (int i = 0; i < 20 && exp_req_pc != 16'h0006; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      checkOutput("hold_req", 32'(imem.imem_req), 32'd1);
      checkOutput("hold_addr", 32'(imem.imem_addr), 32'h0006);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Plan 6: wrap at the top of the address space, then reset mid-stream.
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    resetDut();
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Random traffic with variable latency, stalls, redirects and one reset.
    mem_lat_max = 3;
    for (int i = 0; i < 700; i++) begin
      if (i == 350) resetDut();
      applyStimulus(($urandom % 100) < 30, ($urandom % 100) < 5, 16'($urandom),
                    ($urandom % 100) < 70, ($urandom % 100) < 75);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the 16-bit pipeline. Owns the program counter and issues in-order word fetches to instruction memory over a req/ready request channel and an rvalid response channel.
- Buffers returned instructions in a small FIFO and presents the head as instr/pcplus2 to the IF/ID pipeline register.
- Honours the hazard unit's stall and the branch unit's redirect. On a redirect it flushes, discarding in-flight responses.

Parameters:
- DEPTH, 2: fetch buffer entries; also the maximum number of outstanding requests.
- RESET_PC, 16'h0000: PC value loaded on reset.
- NOP_INSTR, 16'hFFFF: bubble encoding driven when no valid instruction is available.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall  input  1  IF/ID hold; the head is not consumed this cycle.
- redirect_valid  input  1  taken branch/jump; flush and restart fetch.
- redirect_pc  input  16  new fetch address, word aligned (bit 0 ignored, forced 0).
- imem_req  output  1  fetch request valid.
- imem_addr  output  16  fetch address.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses return in request order, minimum 1 cycle after acceptance.
- imem_rdata  input  16  instruction word.
- instr_out  output  16  to IF/ID instr_in.
- pcplus2_out  output  16  to IF/ID pcplus2_in.
- fetch_valid  output  1  the buffer head is a real instruction.

Behaviour:
- Reset (asynchronous, reset_n low):
  - fetch_pc = RESET_PC.
  - Buffer empty, outstanding = 0, discard = 0.
  - imem_req = 0, instr_out = NOP_INSTR, pcplus2_out = 0, fetch_valid = 0.
  - Memory shares reset_n, so no pre-reset response arrives afterwards.
- States:
  - RESET_HOLD: the first cycle after reset_n rises; imem_req = 0.
  - RUN: normal operation, entered unconditionally from RESET_HOLD.
- Issue (RUN):
  - imem_req = 1 when (count + outstanding) < DEPTH and redirect_valid = 0.
  - imem_addr = fetch_pc.
  - Handshake: the request is accepted when imem_req & imem_ready. On acceptance, fetch_pc += 2 (wraps 16'hFFFE -> 16'h0000) and outstanding += 1.
  - imem_req and imem_addr stay stable until accepted, unless a redirect occurs.
- Response:
  - On imem_rvalid with discard = 0: push {imem_rdata, addr+2} into the buffer. The entry's addr is tracked in an internal in-order tag FIFO (depth DEPTH). Outstanding -= 1.
  - On imem_rvalid with discard > 0: drop the data; discard -= 1, outstanding -= 1.
  - A push is visible at the head the following cycle. There is no same-cycle bypass, so fetch-to-output latency is at least 2 cycles after acceptance.
- Output:
  - Buffer non-empty: instr_out/pcplus2_out = head entry, fetch_valid = 1.
  - Buffer empty: instr_out = NOP_INSTR, pcplus2_out = 0, fetch_valid = 0.
  - Outputs are combinational from registered buffer state only.
- Consume: pop the head when fetch_valid & !stall & !redirect_valid.
- Redirect (takes priority over stall, issue, pop and push):
  - Buffer cleared.
  - fetch_pc = redirect_pc & 16'hFFFE.
  - discard = outstanding (minus 1 if imem_rvalid arrives the same cycle; that response is itself dropped).
  - The tag FIFO is cleared.
  - imem_req = 0 in the redirect cycle; issue resumes the next cycle.
- Back-to-back redirects: each reloads fetch_pc. Discard accumulates to the total outstanding count, never exceeding DEPTH.
- Full: count = DEPTH blocks issue. Simultaneous push and pop keeps count constant.
- Stall with buffer full: no further requests are issued and no data is lost.
- The buffer never overflows: the issue credit rule guarantees it, and an assertion checks it.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR and RESET_PC constants.
  - The fetch_entry_t typedef {instr[15:0], pcplus2[15:0]}.
  - The state enum {RESET_HOLD, RUN}.
- One sub-module, fetch_fifo: a parameterised DEPTH-entry synchronous FIFO with push, pop and clear, exposing head, count, full and empty. It is instantiated twice: as the instruction buffer (32-bit entries) and as the address tag FIFO (16-bit entries).

Test Plan:
1. Reset then memory always ready with 1-cycle latency -> requests to 0x0000, 0x0002, 0x0004; outputs (instr, pcplus2) = (mem[0], 0x0002), (mem[2], 0x0004) on consecutive cycles; fetch_valid first high 2 cycles after the first acceptance.
2. Hold stall=1 for 5 cycles after the first instruction -> exactly DEPTH=2 entries buffered, imem_req drops to 0, instr_out unchanged; release stall -> the next outputs are in order with no skip or duplicate.
3. Apply redirect_pc=0x0041 with 2 requests outstanding -> fetch_pc = 0x0040, both late responses dropped, output NOP_INSTR/0 until mem[0x40] appears with pcplus2 = 0x0042.
4. Assert redirect and stall in the same cycle, with a response arriving that cycle -> the buffer flushes, the response is dropped, and fetch restarts at the redirect target.
5. Set imem_ready low for 3 cycles -> imem_req/imem_addr stay stable at 0x0006; fetch_pc does not advance until acceptance.
6. Start at fetch_pc = 0xFFFE -> pcplus2_out = 0x0000 and the next request address is 0x0000; assert reset_n low mid-stream -> all outputs return to their reset values immediately.
